// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline stage: opcodes, control-vector
// field layout, the per-opcode control encodings and small decode helpers.
package id_ex_stage_pkg;

    // Primary opcodes (Instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    // Control field widths
    localparam int unsigned WB_W  = 2;
    localparam int unsigned MEM_W = 3;
    localparam int unsigned EX_W  = 4;

    // WB field: {RegWrite, MemtoReg}
    localparam int unsigned WB_REGWRITE = 1;
    localparam int unsigned WB_MEMTOREG = 0;

    // MEM field: {Branch, MemRead, MemWrite}
    localparam int unsigned MEM_BRANCH   = 2;
    localparam int unsigned MEM_MEMREAD  = 1;
    localparam int unsigned MEM_MEMWRITE = 0;

    // EX field: {RegDst, ALUOp[1:0], ALUSrc}
    localparam int unsigned EX_REGDST    = 3;
    localparam int unsigned EX_ALUOP_LSB = 1;
    localparam int unsigned EX_ALUSRC    = 0;

    typedef struct packed {
        logic [WB_W-1:0]  wb;
        logic [MEM_W-1:0] mem;
        logic [EX_W-1:0]  ex;
    } ctrl_t;

    // Per-opcode encodings built from the field positions
    localparam logic [WB_W-1:0]  WB_RTYPE  = WB_W'(1 << WB_REGWRITE);
    localparam logic [WB_W-1:0]  WB_LW     = WB_W'(1 << WB_REGWRITE) | WB_W'(1 << WB_MEMTOREG);
    localparam logic [MEM_W-1:0] MEM_LW    = MEM_W'(1 << MEM_MEMREAD);
    localparam logic [MEM_W-1:0] MEM_SW    = MEM_W'(1 << MEM_MEMWRITE);
    localparam logic [MEM_W-1:0] MEM_BEQ   = MEM_W'(1 << MEM_BRANCH);
    localparam logic [EX_W-1:0]  EX_RTYPE  = EX_W'(1 << EX_REGDST) | EX_W'(2 << EX_ALUOP_LSB);
    localparam logic [EX_W-1:0]  EX_MEMACC = EX_W'(1 << EX_ALUSRC);
    localparam logic [EX_W-1:0]  EX_BEQ    = EX_W'(1 << EX_ALUOP_LSB);

    localparam ctrl_t CTRL_NOP   = '{wb: '0,       mem: '0,      ex: '0};
    localparam ctrl_t CTRL_RTYPE = '{wb: WB_RTYPE, mem: '0,      ex: EX_RTYPE};
    localparam ctrl_t CTRL_LW    = '{wb: WB_LW,    mem: MEM_LW,  ex: EX_MEMACC};
    localparam ctrl_t CTRL_SW    = '{wb: '0,       mem: MEM_SW,  ex: EX_MEMACC};
    localparam ctrl_t CTRL_BEQ   = '{wb: '0,       mem: MEM_BEQ, ex: EX_BEQ};

    // Main control decoder; unknown opcodes decode to a NOP
    function automatic ctrl_t decode_ctrl(input logic [5:0] op);
        case (op)
            OP_RTYPE: return CTRL_RTYPE;
            OP_LW:    return CTRL_LW;
            OP_SW:    return CTRL_SW;
            OP_BEQ:   return CTRL_BEQ;
            default:  return CTRL_NOP;
        endcase
    endfunction

    // Opcodes that read rt as a source operand (lw writes rt instead)
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_file.sv
// Register file: REG_CNT x DATA_W, two combinational read ports, one write port.
// Register 0 reads as zero and ignores writes; a read of the register being
// written in the same cycle returns the incoming write data.
// Ports: clk, rst (async, active-high, clears all registers), we/waddr/wdata
// write port, raddr1/raddr2 read addresses, rdata1/rdata2 read data.
module reg_file #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_CNT = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [$clog2(REG_CNT)-1:0] waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [$clog2(REG_CNT)-1:0] raddr1,
    input  logic [$clog2(REG_CNT)-1:0] raddr2,
    output logic [DATA_W-1:0]          rdata1,
    output logic [DATA_W-1:0]          rdata2
);

    localparam int unsigned AW = $clog2(REG_CNT);

    logic [DATA_W-1:0] regs [REG_CNT];
    logic              wr_hit;

    // Effective write: never to r0, never while in reset
    assign wr_hit = we && (waddr != '0) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_CNT); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports with write-through bypass
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        if (raddr1 == AW'(0)) begin
            rdata1 = '0;
        end else if (wr_hit && (waddr == raddr1)) begin
            rdata1 = wdata;
        end
        if (raddr2 == AW'(0)) begin
            rdata2 = '0;
        end else if (wr_hit && (waddr == raddr2)) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID stage with ID/EX pipeline register: decodes the IF/ID instruction, reads
// the register file, detects load-use hazards and registers all fields for EX.
// Ports:
//   Clk, Rst               clock, async active-high reset
//   Instr, IF_ID_Valid     instruction from IF/ID and its valid flag
//   PC_IN                  PC+4 of the instruction
//   PCSrc                  branch taken: squash the instruction in ID
//   RegWrite/WriteReg/WriteData  write-back port
//   EX_MemRead, EX_Rt      load in EX and its destination register
//   Stall                  combinational hazard stall (holds PC and IF/ID)
//   PC_OUT..VALID_OUT      registered ID/EX fields
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_CNT = 32
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [31:0]                Instr,
    input  logic                       IF_ID_Valid,
    input  logic [DATA_W-1:0]          PC_IN,
    input  logic                       PCSrc,
    input  logic                       RegWrite,
    input  logic [$clog2(REG_CNT)-1:0] WriteReg,
    input  logic [DATA_W-1:0]          WriteData,
    input  logic                       EX_MemRead,
    input  logic [$clog2(REG_CNT)-1:0] EX_Rt,
    output logic                       Stall,
    output logic [DATA_W-1:0]          PC_OUT,
    output logic [DATA_W-1:0]          RD1_OUT,
    output logic [DATA_W-1:0]          RD2_OUT,
    output logic [DATA_W-1:0]          IMM_OUT,
    output logic [$clog2(REG_CNT)-1:0] RS_OUT,
    output logic [$clog2(REG_CNT)-1:0] WR1_OUT,
    output logic [$clog2(REG_CNT)-1:0] WR2_OUT,
    output logic [WB_W-1:0]            WB_OUT,
    output logic [MEM_W-1:0]           MEM_OUT,
    output logic [EX_W-1:0]            EX_OUT,
    output logic                       VALID_OUT
);

    localparam int unsigned AW = $clog2(REG_CNT);

    logic [5:0]        opcode;
    logic [AW-1:0]     rs;
    logic [AW-1:0]     rt;
    logic [AW-1:0]     rd;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    ctrl_t             ctrl;
    logic              load_use;
    logic              bubble;

    // Instruction field extraction (register fields keep their low AW bits)
    assign opcode  = Instr[31:26];
    assign rs      = AW'(Instr[25:21]);
    assign rt      = AW'(Instr[20:16]);
    assign rd      = AW'(Instr[15:11]);
    assign imm_ext = DATA_W'($signed(Instr[15:0]));
    assign ctrl    = decode_ctrl(opcode);

    reg_file #(
        .DATA_W (DATA_W),
        .REG_CNT(REG_CNT)
    ) u_reg_file (
        .clk   (Clk),
        .rst   (Rst),
        .we    (RegWrite),
        .waddr (WriteReg),
        .wdata (WriteData),
        .raddr1(rs),
        .raddr2(rt),
        .rdata1(rd1),
        .rdata2(rd2)
    );

    // Load-use hazard: the load in EX produces a register this instruction reads
    assign load_use = IF_ID_Valid && EX_MemRead && (EX_Rt != AW'(0)) &&
                      ((EX_Rt == rs) || ((EX_Rt == rt) && reads_rt(opcode)));

    // A taken branch squashes the instruction anyway, so it overrides the stall
    assign Stall  = load_use && !PCSrc && !Rst;
    assign bubble = Stall || PCSrc || !IF_ID_Valid;

    // ID/EX pipeline register; data fields always load, controls zero on bubble
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            PC_OUT    <= '0;
            RD1_OUT   <= '0;
            RD2_OUT   <= '0;
            IMM_OUT   <= '0;
            RS_OUT    <= '0;
            WR1_OUT   <= '0;
            WR2_OUT   <= '0;
            WB_OUT    <= '0;
            MEM_OUT   <= '0;
            EX_OUT    <= '0;
            VALID_OUT <= 1'b0;
        end else begin
            PC_OUT  <= PC_IN;
            RD1_OUT <= rd1;
            RD2_OUT <= rd2;
            IMM_OUT <= imm_ext;
            RS_OUT  <= rs;
            WR1_OUT <= rt;
            WR2_OUT <= rd;
            if (bubble) begin
                WB_OUT    <= '0;
                MEM_OUT   <= '0;
                EX_OUT    <= '0;
                VALID_OUT <= 1'b0;
            end else begin
                WB_OUT    <= ctrl.wb;
                MEM_OUT   <= ctrl.mem;
                EX_OUT    <= ctrl.ex;
                VALID_OUT <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a 32-bit/32-register instance exercised by a
// linear sequence of steps, plus a 16-bit/8-register instance for width checks.
module tb_id_ex_stage;

    logic        Clk;
    logic        Rst;
    logic [31:0] Instr;
    logic        IF_ID_Valid;
    logic [31:0] PC_IN;
    logic        PCSrc;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        EX_MemRead;
    logic [4:0]  EX_Rt;
    logic        Stall;
    logic [31:0] PC_OUT, RD1_OUT, RD2_OUT, IMM_OUT;
    logic [4:0]  RS_OUT, WR1_OUT, WR2_OUT;
    logic [1:0]  WB_OUT;
    logic [2:0]  MEM_OUT;
    logic [3:0]  EX_OUT;
    logic        VALID_OUT;

    logic [31:0] instr16;
    logic [15:0] pc16, wdata16;
    logic [2:0]  wreg16, exrt16;
    logic        stall16;
    logic [15:0] pc_out16, rd1_out16, rd2_out16, imm_out16;
    logic [2:0]  rs_out16, wr1_out16, wr2_out16;
    logic [1:0]  wb_out16;
    logic [2:0]  mem_out16;
    logic [3:0]  ex_out16;
    logic        valid_out16;

    int vectors;
    int miscompares;

    id_ex_stage #(.DATA_W(32), .REG_CNT(32)) dut (
        .Clk(Clk), .Rst(Rst), .Instr(Instr), .IF_ID_Valid(IF_ID_Valid),
        .PC_IN(PC_IN), .PCSrc(PCSrc), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt),
        .Stall(Stall), .PC_OUT(PC_OUT), .RD1_OUT(RD1_OUT), .RD2_OUT(RD2_OUT),
        .IMM_OUT(IMM_OUT), .RS_OUT(RS_OUT), .WR1_OUT(WR1_OUT), .WR2_OUT(WR2_OUT),
        .WB_OUT(WB_OUT), .MEM_OUT(MEM_OUT), .EX_OUT(EX_OUT), .VALID_OUT(VALID_OUT)
    );

    id_ex_stage #(.DATA_W(16), .REG_CNT(8)) dut16 (
        .Clk(Clk), .Rst(Rst), .Instr(instr16), .IF_ID_Valid(1'b1),
        .PC_IN(pc16), .PCSrc(1'b0), .RegWrite(1'b0), .WriteReg(wreg16),
        .WriteData(wdata16), .EX_MemRead(1'b0), .EX_Rt(exrt16),
        .Stall(stall16), .PC_OUT(pc_out16), .RD1_OUT(rd1_out16), .RD2_OUT(rd2_out16),
        .IMM_OUT(imm_out16), .RS_OUT(rs_out16), .WR1_OUT(wr1_out16), .WR2_OUT(wr2_out16),
        .WB_OUT(wb_out16), .MEM_OUT(mem_out16), .EX_OUT(ex_out16), .VALID_OUT(valid_out16)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Rst         = 1'b1;
        IF_ID_Valid = 1'b1;
        PCSrc       = 1'b0;
        RegWrite    = 1'b0;
        WriteReg    = 5'd0;
        WriteData   = 32'h0;
        PC_IN       = 32'h0000_0100;
        // hazard-shaped inputs while in reset: Stall must stay low
        EX_MemRead  = 1'b1;
        EX_Rt       = 5'd4;
        Instr       = itype(6'h2B, 5'd2, 5'd4, 16'd8);
        instr16     = itype(6'h23, 5'd2, 5'd1, 16'hFFFC);
        pc16        = 16'h0040;
        wreg16      = 3'd0;
        wdata16     = 16'h0;
        exrt16      = 3'd0;

        // reset state
        #1;
        chk("rst_valid", 64'(VALID_OUT), 64'd0);
        chk("rst_stall", 64'(Stall), 64'd0);
        chk("rst_pc", 64'(PC_OUT), 64'd0);
        chk("rst_ctrl", 64'({WB_OUT, MEM_OUT, EX_OUT}), 64'd0);
        step();
        chk("rst_hold_valid", 64'(VALID_OUT), 64'd0);

        // release reset; first edge is a normal one: write r5, read it via bypass
        Rst        = 1'b0;
        EX_MemRead = 1'b0;
        RegWrite   = 1'b1;
        WriteReg   = 5'd5;
        WriteData  = 32'hDEAD_BEEF;
        Instr      = rtype(5'd5, 5'd0, 5'd3);
        PC_IN      = 32'h0000_0104;
        step();
        chk("wr5_rd1", 64'(RD1_OUT), 64'hDEAD_BEEF);
        chk("wr5_valid", 64'(VALID_OUT), 64'd1);
        chk("wr5_pc", 64'(PC_OUT), 64'h104);
        chk("wr5_rs", 64'(RS_OUT), 64'd5);
        chk("wr5_rd", 64'(WR2_OUT), 64'd3);
        // width instance: lw r1,-4(r2)
        chk("w16_imm", 64'(imm_out16), 64'hFFFC);
        chk("w16_wr1", 64'(wr1_out16), 64'd1);
        chk("w16_mem", 64'(mem_out16), 64'b010);
        chk("w16_wb", 64'(wb_out16), 64'b11);
        chk("w16_ex", 64'(ex_out16), 64'b0001);

        // mid-cycle reset clears outputs before the next edge
        RegWrite = 1'b0;
        #3;
        Rst = 1'b1;
        #1;
        chk("mid_rst_rd1", 64'(RD1_OUT), 64'd0);
        chk("mid_rst_valid", 64'(VALID_OUT), 64'd0);
        chk("mid_rst_ctrl", 64'({WB_OUT, MEM_OUT, EX_OUT}), 64'd0);
        chk("mid_rst_pc", 64'(PC_OUT), 64'd0);
        chk("mid_rst_w16", 64'(valid_out16), 64'd0);
        #1;
        Rst = 1'b0;
        step();
        chk("r5_cleared", 64'(RD1_OUT), 64'd0);
        chk("r5_cleared_valid", 64'(VALID_OUT), 64'd1);

        // write-through bypass: add r3,r7,r0 while writing r7
        RegWrite  = 1'b1;
        WriteReg  = 5'd7;
        WriteData = 32'h1234_5678;
        Instr     = rtype(5'd7, 5'd0, 5'd3);
        step();
        chk("byp_rd1", 64'(RD1_OUT), 64'h1234_5678);
        chk("byp_ex", 64'(EX_OUT), 64'b1100);
        chk("byp_wb", 64'(WB_OUT), 64'b10);
        chk("byp_mem", 64'(MEM_OUT), 64'b000);
        chk("byp_valid", 64'(VALID_OUT), 64'd1);

        // stored value read on both ports
        RegWrite = 1'b0;
        Instr    = rtype(5'd7, 5'd7, 5'd3);
        step();
        chk("r7_rd1", 64'(RD1_OUT), 64'h1234_5678);
        chk("r7_rd2", 64'(RD2_OUT), 64'h1234_5678);

        // r0 ignores writes, including on the bypass path
        RegWrite  = 1'b1;
        WriteReg  = 5'd0;
        WriteData = 32'hFFFF_FFFF;
        Instr     = rtype(5'd0, 5'd0, 5'd3);
        step();
        chk("r0_bypass", 64'(RD1_OUT), 64'd0);
        RegWrite = 1'b0;
        step();
        chk("r0_read", 64'(RD1_OUT), 64'd0);

        // load-use on rt of sw r4,8(r2)
        EX_MemRead = 1'b1;
        EX_Rt      = 5'd4;
        Instr      = itype(6'h2B, 5'd2, 5'd4, 16'd8);
        #1;
        chk("lu_stall", 64'(Stall), 64'd1);
        step();
        chk("lu_valid", 64'(VALID_OUT), 64'd0);
        chk("lu_ctrl", 64'({WB_OUT, MEM_OUT, EX_OUT}), 64'd0);
        EX_MemRead = 1'b0;
        #1;
        chk("lu_release_stall", 64'(Stall), 64'd0);
        step();
        chk("sw_mem", 64'(MEM_OUT), 64'b001);
        chk("sw_ex", 64'(EX_OUT), 64'b0001);
        chk("sw_wb", 64'(WB_OUT), 64'b00);
        chk("sw_imm", 64'(IMM_OUT), 64'd8);
        chk("sw_wr1", 64'(WR1_OUT), 64'd4);
        chk("sw_valid", 64'(VALID_OUT), 64'd1);

        // lw writes rt rather than reading it: no hazard on rt match
        EX_MemRead = 1'b1;
        EX_Rt      = 5'd4;
        Instr      = itype(6'h23, 5'd2, 5'd4, 16'hFFFC);
        #1;
        chk("lw_rt_nostall", 64'(Stall), 64'd0);
        step();
        chk("lw_mem", 64'(MEM_OUT), 64'b010);
        chk("lw_wb", 64'(WB_OUT), 64'b11);
        chk("lw_imm", 64'(IMM_OUT), 64'hFFFF_FFFC);

        // load-use on rs of lw
        Instr = itype(6'h23, 5'd4, 5'd9, 16'd0);
        #1;
        chk("lw_rs_stall", 64'(Stall), 64'd1);

        // EX_Rt = 0 never stalls
        EX_Rt = 5'd0;
        Instr = rtype(5'd0, 5'd0, 5'd1);
        #1;
        chk("rt0_nostall", 64'(Stall), 64'd0);

        // flush beats stall: beq r4,r1 with load-use and PCSrc
        EX_Rt = 5'd4;
        PCSrc = 1'b1;
        Instr = itype(6'h04, 5'd4, 5'd1, 16'h0010);
        #1;
        chk("flush_stall", 64'(Stall), 64'd0);
        step();
        chk("flush_ctrl", 64'({WB_OUT, MEM_OUT, EX_OUT}), 64'd0);
        chk("flush_valid", 64'(VALID_OUT), 64'd0);

        // beq decodes normally without flush or hazard
        PCSrc      = 1'b0;
        EX_MemRead = 1'b0;
        step();
        chk("beq_mem", 64'(MEM_OUT), 64'b100);
        chk("beq_ex", 64'(EX_OUT), 64'b0010);
        chk("beq_wb", 64'(WB_OUT), 64'b00);

        // unknown opcode: valid NOP
        Instr = itype(6'h08, 5'd1, 5'd2, 16'h0005);
        step();
        chk("nop_ctrl", 64'({WB_OUT, MEM_OUT, EX_OUT}), 64'd0);
        chk("nop_valid", 64'(VALID_OUT), 64'd1);

        // invalid IF/ID slot: bubble and no stall
        IF_ID_Valid = 1'b0;
        EX_MemRead  = 1'b1;
        EX_Rt       = 5'd7;
        Instr       = rtype(5'd7, 5'd0, 5'd3);
        #1;
        chk("inv_stall", 64'(Stall), 64'd0);
        step();
        chk("inv_valid", 64'(VALID_OUT), 64'd0);
        chk("inv_ctrl", 64'({WB_OUT, MEM_OUT, EX_OUT}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32: register and datapath width in bits (>= 16).
REQ-002 Parameter REG_CNT, default 32: number of architectural registers (power of two, >= 8); AW = log2(REG_CNT).
REQ-003 Clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Rst  in  1  reset, asynchronous, active-high.
REQ-005 Instr  in  32  instruction from IF/ID; IF_ID_Valid  in  1  Instr/PC_IN meaningful.
REQ-006 PC_IN  in  DATA_W  PC+4 of the instruction.
REQ-007 PCSrc  in  1  branch taken: squash the instruction in ID.
REQ-008 RegWrite  in  1; WriteReg  in  AW; WriteData  in  DATA_W  write-back port.
REQ-009 EX_MemRead  in  1; EX_Rt  in  AW  load currently in EX and its destination.
REQ-010 Stall  out  1  combinational; holds PC and IF/ID when high.
REQ-011 PC_OUT, RD1_OUT, RD2_OUT, IMM_OUT  out  DATA_W  registered PC, rs data, rt data, sign-extended Instr[15:0].
REQ-012 RS_OUT, WR1_OUT, WR2_OUT  out  AW  registered rs, rt, rd fields (low AW bits).
REQ-013 WB_OUT  out  2 {RegWrite,MemtoReg}; MEM_OUT  out  3 {Branch,MemRead,MemWrite}; EX_OUT  out  4 {RegDst,ALUOp[1:0],ALUSrc}; VALID_OUT  out  1.

Function
REQ-014 Decode on Instr[31:26]: 0x00 R-type -> EX 1100, MEM 000, WB 10; 0x23 lw -> EX 0001, MEM 010, WB 11; 0x2B sw -> EX 0001, MEM 001, WB 00; 0x04 beq -> EX 0010, MEM 100, WB 00; any other opcode -> all zero (NOP).
REQ-015 Register file: REG_CNT x DATA_W; register 0 reads 0; writes to register 0 ignored.
REQ-016 Write on rising edge when RegWrite=1.
REQ-017 Same-cycle read of WriteReg with RegWrite=1 (nonzero address) returns WriteData (write-through bypass).
REQ-018 Load-use hazard: Stall = IF_ID_Valid & EX_MemRead & (EX_Rt != 0) & (EX_Rt == rs | (EX_Rt == rt & opcode in {R-type, sw, beq})) & ~PCSrc & ~Rst.
REQ-019 Latency: one cycle; ID/EX captures decoded fields at each rising edge; no enable, never holds.
REQ-020 Bubble: when Stall, PCSrc, or ~IF_ID_Valid at the edge, WB_OUT, MEM_OUT, EX_OUT load 0 and VALID_OUT loads 0; data fields load normally (don't-care).
REQ-021 Otherwise VALID_OUT loads 1 and control outputs load REQ-014 values.
REQ-022 PCSrc and Stall simultaneously asserted by inputs: PCSrc wins; Stall output 0, bubble inserted.
REQ-023 Immediate sign-extension replicates Instr[15] into bits DATA_W-1..16.
REQ-024 Stalled instruction re-presented next cycle decodes normally once EX_MemRead drops (one bubble per load-use).

Reset
REQ-025 Rst high clears all registers of the register file and all ID/EX outputs to 0 immediately, independent of Clk.
REQ-026 While Rst high, Stall = 0 and writes ignored.
REQ-027 Rst deasserted: first rising edge after behaves as normal operation; no extra dead cycle.

Structure
REQ-028 Shared package holds opcode constants, control-vector encodings (REQ-014), WB/MEM/EX field bit positions and widths.
REQ-029 One sub-module, reg_file, parametrised by DATA_W and REG_CNT, containing REQ-015..017 and its reset.
REQ-030 Hazard logic and decoder are combinational inside id_ex_stage; only ID/EX and reg_file hold state.

Verification
REQ-031 Reset: write r5=0xDEADBEEF, assert Rst mid-cycle -> all outputs 0 before next edge; read r5 after -> 0.
REQ-032 Bypass: RegWrite=1, WriteReg=7, WriteData=0x12345678, Instr add r3,r7,r0 same cycle -> next edge RD1_OUT=0x12345678, EX_OUT=1100, WB_OUT=10, VALID_OUT=1.
REQ-033 r0: write 0xFFFFFFFF to r0, then read rs=0 -> RD1_OUT=0.
REQ-034 Load-use: EX_MemRead=1, EX_Rt=4, Instr sw r4,8(r2) -> Stall=1, next edge VALID_OUT=0, controls 0; drop EX_MemRead -> next edge MEM_OUT=001, IMM_OUT=8.
REQ-035 Flush priority: PCSrc=1 with load-use condition and beq in ID -> Stall=0, next edge all controls 0, VALID_OUT=0.
REQ-036 Width: DATA_W=16, REG_CNT=8, lw r1,-4(r2) -> IMM_OUT=0xFFFC, WR1_OUT=1, MEM_OUT=010, WB_OUT=11.
